// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier with per-operand signedness.
// Retires two multiplier bits per cycle behind a start/ready handshake with a one-cycle done strobe.
module booth_radix4_multiplier #(
  parameter int MUL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sign1,
  input  logic                     sign2,
  input  logic [MUL_WIDTH-1:0]     data_in1,
  input  logic [MUL_WIDTH-1:0]     data_in2,
  output logic [2*MUL_WIDTH-1:0]   data_out,
  output logic                     ready,
  output logic                     done,
  output logic                     state_dbg
);

  // Handshake: start is accepted on a rising edge only while ready=1; once
  // accepted, ready stays low until the result edge, which also pulses done
  // for exactly one cycle. start seen while ready=0 is dropped, never queued.

  localparam int STEPS = (MUL_WIDTH + 2 + 1) / 2;
  localparam int EXT_W = 2 * STEPS;
  localparam int ACC_W = 2 * EXT_W;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t                   state_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         acc_d;
  logic [ACC_W-1:0]         a_sh_q;
  logic [ACC_W-1:0]         pp;
  logic [EXT_W:0]           b_sh_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [2*MUL_WIDTH-1:0]   data_out_q;
  logic                     ready_q;
  logic                     done_q;
  logic [ACC_W-1:0]         a_ext;
  logic [EXT_W-1:0]         b_ext;

  assign a_ext = {{(ACC_W - MUL_WIDTH){sign1 & data_in1[MUL_WIDTH-1]}}, data_in1};
  assign b_ext = {{(EXT_W - MUL_WIDTH){sign2 & data_in2[MUL_WIDTH-1]}}, data_in2};

  // b_sh_q[2:0] is the current Booth triplet; bit 0 holds b[2i-1] (b[-1]=0 at start).
  always_comb begin
    pp = '0;
    case (b_sh_q[2:0])
      3'b001, 3'b010: pp = a_sh_q;
      3'b011:         pp = a_sh_q << 1;
      3'b100:         pp = -(a_sh_q << 1);
      3'b101, 3'b110: pp = -a_sh_q;
      default:        pp = '0;
    endcase
    acc_d = acc_q + pp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a_ext;
            b_sh_q  <= {b_ext, 1'b0};
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          a_sh_q <= a_sh_q << 2;
          b_sh_q <= {{2{b_sh_q[EXT_W]}}, b_sh_q[EXT_W:2]};
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            data_out_q <= acc_d[2*MUL_WIDTH-1:0];
            ready_q    <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign state_dbg = (state_q == CALC);

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Bench for booth_radix4_multiplier: a W=8 and a W=4 instance checked against
// an integer-arithmetic product model.
module tb_booth_radix4_multiplier;

  logic        clk;
  logic        rst_n;
  int          checks;
  int          failures;

  logic        start8, s1_8, s2_8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;
  logic        rdy8, done8, st8;

  logic        start4, s1_4, s2_4;
  logic [3:0]  a4, b4;
  logic [7:0]  out4;
  logic        rdy4, done4, st4;

  booth_radix4_multiplier #(.MUL_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sign1(s1_8), .sign2(s2_8),
    .data_in1(a8), .data_in2(b8), .data_out(out8), .ready(rdy8),
    .done(done8), .state_dbg(st8)
  );

  booth_radix4_multiplier #(.MUL_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sign1(s1_4), .sign2(s2_4),
    .data_in1(a4), .data_in2(b4), .data_out(out4), .ready(rdy4),
    .done(done4), .state_dbg(st4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: operand values interpreted by sign flag, plain multiply
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s1, input logic s2);
    longint av, bv, p;
    if (s1) av = longint'($signed(a)); else av = longint'({56'd0, a});
    if (s2) bv = longint'($signed(b)); else bv = longint'({56'd0, b});
    p = av * bv;
    return p[15:0];
  endfunction

  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic s1, input logic s2);
    longint av, bv, p;
    if (s1) av = longint'($signed(a)); else av = longint'({60'd0, a});
    if (s2) bv = longint'($signed(b)); else bv = longint'({60'd0, b});
    p = av * bv;
    return p[7:0];
  endfunction

  // driver tasks: called just after a rising edge with the DUT idle
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic s1, input logic s2, input string name);
    logic [15:0] exp;
    int cyc;
    exp = model8(a, b, s1, s2);
    a8 = a; b8 = b; s1_8 = s1; s2_8 = s2; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (rdy8 !== 1'b0) begin
      failures++; $display("FAIL %s ready_after_accept got=%0b exp=0", name, rdy8);
    end
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (done8 !== 1'b1 && cyc < 20);
    checks++;
    if (cyc !== 5) begin
      failures++; $display("FAIL %s latency got=%0d exp=5", name, cyc);
    end
    checks++;
    if (out8 !== exp) begin
      failures++; $display("FAIL %s product a=%h b=%h s=%0b%0b got=%h exp=%h", name, a, b, s1, s2, out8, exp);
    end
    checks++;
    if (rdy8 !== 1'b1) begin
      failures++; $display("FAIL %s ready_at_done got=%0b exp=1", name, rdy8);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || out8 !== exp) begin
      failures++; $display("FAIL %s done_fall_hold done=%0b out=%h exp_out=%h", name, done8, out8, exp);
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      input logic s1, input logic s2, input string name);
    logic [7:0] exp;
    int cyc;
    exp = model4(a, b, s1, s2);
    a4 = a; b4 = b; s1_4 = s1; s2_4 = s2; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (done4 !== 1'b1 && cyc < 20);
    checks++;
    if (cyc !== 3) begin
      failures++; $display("FAIL %s latency got=%0d exp=3", name, cyc);
    end
    checks++;
    if (out4 !== exp || rdy4 !== 1'b1) begin
      failures++; $display("FAIL %s product a=%h b=%h s=%0b%0b got=%h rdy=%0b exp=%h rdy=1", name, a, b, s1, s2, out4, rdy4, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (done4 !== 1'b0) begin
      failures++; $display("FAIL %s done_fall got=%0b exp=0", name, done4);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out8 !== 16'h0 || rdy8 !== 1'b1 || done8 !== 1'b0 || st8 !== 1'b0) begin
      failures++; $display("FAIL reset_w8 out=%h rdy=%0b done=%0b st=%0b exp out=0 rdy=1 done=0 st=0", out8, rdy8, done8, st8);
    end
    checks++;
    if (out4 !== 8'h0 || rdy4 !== 1'b1 || done4 !== 1'b0) begin
      failures++; $display("FAIL reset_w4 out=%h rdy=%0b done=%0b exp out=0 rdy=1 done=0", out4, rdy4, done4);
    end
  endtask

  task automatic test_w4();
    run4(4'd6, 4'd3, 1'b0, 1'b0, "w4_6x3");
    run4(4'hA, 4'd3, 1'b1, 1'b1, "w4_m6x3");
    run4(4'hA, 4'hD, 1'b1, 1'b1, "w4_m6xm3");
    run4(4'h9, 4'hE, 1'b1, 1'b1, "w4_m7xm2");
    run4(4'h8, 4'h8, 1'b1, 1'b1, "w4_m8xm8");
    run4(4'hF, 4'hF, 1'b0, 1'b0, "w4_15x15");
    run4(4'h8, 4'hF, 1'b1, 1'b0, "w4_m8x15");
    for (int i = 0; i < 20; i++)
      run4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "w4_rand");
  endtask

  task automatic test_boundaries();
    run8(8'hFF, 8'hFF, 1'b0, 1'b0, "w8_255x255");
    run8(8'h80, 8'h80, 1'b1, 1'b1, "w8_m128xm128");
    run8(8'h0F, 8'hF8, 1'b0, 1'b1, "w8_15xm8");
    run8(8'h00, 8'hFF, 1'b1, 1'b1, "w8_0xm1");
    run8(8'h80, 8'hFF, 1'b1, 1'b0, "w8_m128x255");
    run8(8'hFF, 8'h80, 1'b0, 1'b1, "w8_255xm128");
    run8(8'h7F, 8'h80, 1'b1, 1'b1, "w8_127xm128");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "w8_rand");
  endtask

  task automatic test_start_ignored();
    int ndone, first;
    logic [15:0] got;
    a8 = 8'd100; b8 = 8'd3; s1_8 = 1'b0; s2_8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0; first = -1; got = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin a8 = 8'd7; b8 = 8'd7; s1_8 = 1'b1; start8 = 1'b1; end
      if (c == 3) start8 = 1'b0;
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        ndone++;
        if (first < 0) begin first = c; got = out8; end
      end
    end
    checks++;
    if (ndone !== 1 || first !== 5) begin
      failures++; $display("FAIL start_ignored done_count=%0d first=%0d exp count=1 first=5", ndone, first);
    end
    checks++;
    if (got !== model8(8'd100, 8'd3, 1'b0, 1'b0) || out8 !== got) begin
      failures++; $display("FAIL start_ignored product got=%h now=%h exp=%h", got, out8, model8(8'd100, 8'd3, 1'b0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ta[3];
    logic [7:0]  tb[3];
    logic        ts[3];
    logic [15:0] exp_q[$];
    logic [15:0] prev, exp;
    int cyc;
    for (int k = 0; k < 3; k++) begin
      ta[k] = 8'($urandom_range(0, 255));
      tb[k] = 8'($urandom_range(0, 255));
      ts[k] = 1'($urandom_range(0, 1));
      exp_q.push_back(model8(ta[k], tb[k], ts[k], ts[k]));
    end
    prev = out8;
    a8 = ta[0]; b8 = tb[0]; s1_8 = ts[0]; s2_8 = ts[0]; start8 = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1; cyc++;
        if (done8 !== 1'b1) begin
          checks++;
          if (out8 !== prev) begin
            failures++; $display("FAIL b2b_hold k=%0d got=%h exp=%h", k, out8, prev);
          end
        end
      end while (done8 !== 1'b1 && cyc < 20);
      exp = exp_q.pop_front();
      checks++;
      if (cyc !== ((k == 0) ? 5 : 6)) begin
        failures++; $display("FAIL b2b_interval k=%0d got=%0d exp=%0d", k, cyc, (k == 0) ? 5 : 6);
      end
      checks++;
      if (out8 !== exp) begin
        failures++; $display("FAIL b2b_product k=%0d got=%h exp=%h", k, out8, exp);
      end
      prev = exp;
      if (k < 2) begin
        a8 = ta[k+1]; b8 = tb[k+1]; s1_8 = ts[k+1]; s2_8 = ts[k+1];
      end else begin
        start8 = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || rdy8 !== 1'b1 || out8 !== prev) begin
      failures++; $display("FAIL b2b_end done=%0b rdy=%0b out=%h exp done=0 rdy=1 out=%h", done8, rdy8, out8, prev);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    a8 = 8'd200; b8 = 8'd200; s1_8 = 1'b0; s2_8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out8 !== 16'h0 || rdy8 !== 1'b1 || done8 !== 1'b0) begin
      failures++; $display("FAIL reset_mid out=%h rdy=%0b done=%0b exp out=0 rdy=1 done=0", out8, rdy8, done8);
    end
    #12 rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || out8 !== 16'h0) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++; $display("FAIL reset_mid_no_done bad_cycles=%0d exp=0", ndone);
    end
    run8(8'd7, 8'd9, 1'b0, 1'b0, "w8_after_reset_7x9");
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    start8 = 1'b0; s1_8 = 1'b0; s2_8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; s1_4 = 1'b0; s2_4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_w4();
    test_boundaries();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
